axi_mem_sram_resp: RTL and testbench

AXI_MEM_SRAM_RESP -- requirements
Module: axi_mem_sram_resp

---
 rtl/axi_mem_sram_resp.sv | 106 ++++++++++
 tb/tb_axi_mem_sram_resp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_sram_resp.sv
// Single-port SRAM responder: zero-fills itself after reset, then serves
// word reads/writes with a fixed, fully pipelined read latency.
module axi_mem_sram_resp #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  req_cs,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_rvalid,
  output logic                  init_done,
  output logic                  req_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       fill_cnt, fill_cnt_nxt;
  logic                   init_wr;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   in_range;
  logic [IDX_W-1:0]       idx;
  logic                   rd_fire, wr_fire, err_nxt;
  logic [DATA_WIDTH-1:0]  rd_data;

  // Registered read stages 1..READ_LAT; the *_pipe views prepend the
  // request-cycle inputs as stage 0 so every stage has the same shape.
  logic [READ_LAT:1]                 vld_q;
  logic [READ_LAT:1][DATA_WIDTH-1:0] dat_q;
  logic [READ_LAT:0]                 vld_pipe;
  logic [READ_LAT:0][DATA_WIDTH-1:0] dat_pipe;

  assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_fire  = req_cs & ~req_we & (state == READY);
  assign wr_fire  = req_cs &  req_we & (state == READY) & in_range;
  assign err_nxt  = req_cs & ((state == INIT) | ~in_range);
  assign rd_data  = in_range ? mem[idx] : '0;

  assign vld_pipe = {vld_q, rd_fire};
  assign dat_pipe = {dat_q, rd_data};

  assign resp_rvalid = vld_q[READ_LAT];
  assign resp_rdata  = dat_q[READ_LAT];
  assign init_done   = (state == READY);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    init_wr      = 1'b0;
    case (state)
      INIT: begin
        init_wr      = 1'b1;
        fill_cnt_nxt = fill_cnt + IDX_W'(1);
        if (fill_cnt == IDX_W'(DEPTH - 1)) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Array has no reset; it becomes defined only through the zero-fill.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      if (init_wr)      mem[fill_cnt] <= '0;
      else if (wr_fire) mem[idx]      <= req_wdata;
    end
  end

  // Data stages load only on a valid beat, so the last stage holds the
  // most recent read result between rvalid pulses.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld_q   <= '0;
      dat_q   <= '0;
      req_err <= 1'b0;
    end else begin
      req_err <= err_nxt;
      for (int k = 1; k <= READ_LAT; k++) begin
        vld_q[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_sram_resp.sv
// Directed bench for axi_mem_sram_resp (DEPTH=16, READ_LAT=2).
module tb_axi_mem_sram_resp;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_cs = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] resp_rdata;
  logic          resp_rvalid;
  logic          init_done;
  logic          req_err;

  int checks = 0;
  int errors = 0;

  axi_mem_sram_resp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LAT(LAT)
  ) dut (
    .clk(clk), .rst_b(rst_b), .req_cs(req_cs), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_rdata(resp_rdata),
    .resp_rvalid(resp_rvalid), .init_done(init_done), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_b = 1'b0;
    req_cs = 1'b0;
    tick;
    tick;
    rst_b = 1'b1;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 40 && !init_done; i++) tick;
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: init_done=%b required 1 within 40 cycles", init_done);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_cs = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick;
    req_cs = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
    req_cs = 1'b1; req_we = 1'b0; req_addr = a;
    tick;
    req_cs = 1'b0;
    repeat (LAT - 1) tick;
    v = resp_rvalid;
    d = resp_rdata;
  endtask

  task automatic test_reset;
    rst_b = 1'b0; req_cs = 1'b1; req_we = 1'b0; req_addr = 16'd3;
    tick;
    tick;
    checks++;
    if (resp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", resp_rvalid); end
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", req_err); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++;
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    req_cs = 1'b0;
  endtask

  task automatic test_init_fill;
    logic v;
    logic [DW-1:0] d;
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL init_low[%0d]: got %b want 0", i, init_done); end
      checks++;
      if (req_err !== (i == 3)) begin errors++; $display("FAIL init_err[%0d]: got %b want %b", i, req_err, (i == 3)); end
      checks++;
      if (resp_rvalid !== 1'b0) begin errors++; $display("FAIL init_rvalid[%0d]: got %b want 0", i, resp_rvalid); end
      req_cs = (i == 2); req_we = 1'b0; req_addr = '0;
      tick;
    end
    req_cs = 1'b0;
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_rise: got %b want 1 after 16 cycles", init_done); end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), v, d);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        errors++; $display("FAIL zero_fill[%0d]: got v=%b d=%h want v=1 d=0", a, v, d);
      end
    end
  endtask

  task automatic test_wr_rd;
    do_write(16'd5, 32'hDEAD_BEEF);
    req_cs = 1'b1; req_we = 1'b0; req_addr = 16'd5;
    tick;
    req_cs = 1'b0;
    checks++;
    if (resp_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rd_early: rvalid=%b want 0", resp_rvalid); end
    tick;
    checks++;
    if (resp_rvalid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_rd: got v=%b d=%h want v=1 d=deadbeef", resp_rvalid, resp_rdata);
    end
    do_write(16'd6, 32'h1234_5678);
    checks++;
    if (resp_rvalid !== 1'b0 || resp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdata_hold: got v=%b d=%h want v=0 d=deadbeef", resp_rvalid, resp_rdata);
    end
    tick;
    checks++;
    if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold2: got %h want deadbeef", resp_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_d [3];
    int k;
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    do_write(16'd1, 32'h11);
    do_write(16'd2, 32'h22);
    do_write(16'd3, 32'h33);
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_cs = (cyc < 3); req_we = 1'b0; req_addr = AW'(cyc + 1);
      tick;
      k = cyc + 1 - LAT;
      checks++;
      if (k >= 0 && k < 3) begin
        if (resp_rvalid !== 1'b1 || resp_rdata !== exp_d[k]) begin
          errors++; $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", cyc, resp_rvalid, resp_rdata, exp_d[k]);
        end
      end else if (resp_rvalid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle[%0d]: rvalid=%b want 0", cyc, resp_rvalid);
      end
    end
    req_cs = 1'b0;
  endtask

  task automatic test_oor;
    logic v;
    logic [DW-1:0] d;
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 32'h100 + a);
    do_read(16'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h103) begin errors++; $display("FAIL pre_oor_read: got v=%b d=%h want v=1 d=103", v, d); end
    // Idle cycles with garbage on the other request fields.
    req_cs = 1'b0; req_we = 1'b1; req_addr = 16'd4; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (req_err !== 1'b0 || resp_rvalid !== 1'b0) begin
        errors++; $display("FAIL idle[%0d]: err=%b rvalid=%b want 0 0", i, req_err, resp_rvalid);
      end
    end
    req_cs = 1'b1; req_we = 1'b1; req_addr = 16'd20; req_wdata = 32'hAA;
    tick;
    req_cs = 1'b0;
    checks++;
    if (req_err !== 1'b1 || resp_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_wr_err: err=%b rvalid=%b want 1 0", req_err, resp_rvalid);
    end
    tick;
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL oor_wr_err_pulse: err=%b want 0", req_err); end
    req_cs = 1'b1; req_we = 1'b0; req_addr = 16'd20;
    tick;
    req_cs = 1'b0;
    checks++;
    if (req_err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: err=%b want 1", req_err); end
    tick;
    checks++;
    if (resp_rvalid !== 1'b1 || resp_rdata !== 32'h0 || req_err !== 1'b0) begin
      errors++; $display("FAIL oor_rd: got v=%b d=%h err=%b want v=1 d=0 err=0", resp_rvalid, resp_rdata, req_err);
    end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), v, d);
      checks++;
      if (v !== 1'b1 || d !== 32'h100 + a) begin
        errors++; $display("FAIL oor_keep[%0d]: got v=%b d=%h want v=1 d=%h", a, v, d, 32'h100 + a);
      end
    end
  endtask

  task automatic test_reset_midop;
    logic v;
    logic [DW-1:0] d;
    do_write(16'd7, 32'h77);
    req_cs = 1'b1; req_we = 1'b0; req_addr = 16'd7;
    tick;
    req_cs = 1'b0;
    rst_b = 1'b0;
    tick;
    checks++;
    if (resp_rvalid !== 1'b0 || init_done !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL midop_reset: v=%b done=%b d=%h want 0 0 0", resp_rvalid, init_done, resp_rdata);
    end
    rst_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (resp_rvalid !== 1'b0 || init_done !== 1'b0) begin
        errors++; $display("FAIL midop_init[%0d]: v=%b done=%b want 0 0", i, resp_rvalid, init_done);
      end
      tick;
    end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL midop_rise: done=%b want 1", init_done); end
    do_read(16'd7, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL midop_refill: got v=%b d=%h want v=1 d=0", v, d); end
  endtask

  initial begin
    tick;
    test_reset;
    test_init_fill;
    wait_ready;
    test_wr_rd;
    test_back_to_back;
    test_oor;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
